// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status in, stage-register control out.
// Ports:
//   status   id_valid, id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
//            ex_branch_taken, ex_muldiv_start, muldiv_done, mem_req, mem_ready
//   control  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, mem_freeze
//   observe  state, stall_cycles, flush_count
// master = pipeline side (drives status), slave = hazard_ctrl (drives control).
interface hazard_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             id_valid;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs2;
    logic [4:0]       ex_rd;
    logic             ex_mem_read;
    logic             ex_branch_taken;
    logic             ex_muldiv_start;
    logic             muldiv_done;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_stall;
    logic             if_id_stall;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             ex_hold;
    logic             mem_freeze;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_muldiv_start, muldiv_done, mem_req, mem_ready,
        input  pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold,
               mem_freeze, state, stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_muldiv_start, muldiv_done, mem_req, mem_ready,
        output pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold,
               mem_freeze, state, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage core: load-use bubbles,
// taken-branch flush, mul/div occupancy and data-memory wait freeze.
// Ports: clk, rst_n (async active-low), hz (hazard_ctrl_if.slave).
// Control outputs are combinational from the registered state and current
// inputs so the stage registers act on the next rising edge.
// Optional macro HAZARD_PERF_CNT_EN: implements stall_cycles / flush_count
// saturating counters; when undefined both read 0 and no flops exist.
module hazard_ctrl #(
    parameter int unsigned LU_BUBBLES = 1,
    parameter int unsigned CNT_W      = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    hazard_ctrl_if.slave hz
);
    localparam int unsigned CW = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LOAD_USE = 2'd1,
        MULDIV   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mwait, lu;
    logic          pc_stall_c, if_id_stall_c, if_id_flush_c;
    logic          id_ex_bubble_c, ex_hold_c, mem_freeze_c;

    assign mwait = hz.mem_req & ~hz.mem_ready;
    assign lu    = hz.id_valid & hz.ex_mem_read & (hz.ex_rd != 5'd0) &
                   ((hz.ex_rd == hz.id_rs1) | (hz.id_uses_rs2 & (hz.ex_rd == hz.id_rs2)));

    // State and bubble counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and control; memory wait overrides everything and freezes the FSM
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        pc_stall_c     = 1'b0;
        if_id_stall_c  = 1'b0;
        if_id_flush_c  = 1'b0;
        id_ex_bubble_c = 1'b0;
        ex_hold_c      = 1'b0;
        mem_freeze_c   = 1'b0;
        if (mwait) begin
            mem_freeze_c  = 1'b1;
            pc_stall_c    = 1'b1;
            if_id_stall_c = 1'b1;
            ex_hold_c     = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (hz.ex_branch_taken) begin
                        if_id_flush_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                    end else if (hz.ex_muldiv_start) begin
                        pc_stall_c    = 1'b1;
                        if_id_stall_c = 1'b1;
                        ex_hold_c     = 1'b1;
                        state_d       = MULDIV;
                    end else if (lu) begin
                        pc_stall_c     = 1'b1;
                        if_id_stall_c  = 1'b1;
                        id_ex_bubble_c = 1'b1;
                        // First bubble is issued here; remaining ones come from LOAD_USE
                        if (LU_BUBBLES > 1) begin
                            cnt_d   = CW'(LU_BUBBLES - 1);
                            state_d = LOAD_USE;
                        end
                    end
                end
                LOAD_USE: begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                    cnt_d          = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = RUN;
                end
                MULDIV: begin
                    if (hz.muldiv_done) begin
                        state_d = RUN;
                    end else begin
                        pc_stall_c    = 1'b1;
                        if_id_stall_c = 1'b1;
                        ex_hold_c     = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign hz.pc_stall     = pc_stall_c;
    assign hz.if_id_stall  = if_id_stall_c;
    assign hz.if_id_flush  = if_id_flush_c;
    assign hz.id_ex_bubble = id_ex_bubble_c;
    assign hz.ex_hold      = ex_hold_c;
    assign hz.mem_freeze   = mem_freeze_c;
    assign hz.state        = 2'(state_q);

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_stall_c && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + CNT_W'(1);
            if (if_id_flush_c && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_count  = flush_q;
`else
    assign hz.stall_cycles = {CNT_W{1'b0}};
    assign hz.flush_count  = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: instance A (LU_BUBBLES=3, 32-bit
// counters) and instance B (LU_BUBBLES=1, 4-bit counters) see identical
// stimulus and are checked every cycle against a behavioural model.
module tb_hazard_ctrl;
    localparam int unsigned CW_A = 32;
    localparam int unsigned CW_B = 4;

    typedef struct packed {
        logic       id_valid;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_uses_rs2;
        logic [4:0] ex_rd;
        logic       ex_mem_read;
        logic       br;
        logic       mds;
        logic       done;
        logic       mreq;
        logic       mrdy;
    } in_t;

    typedef struct {
        in_t        in;
        logic [5:0] exp;   // {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, ex_hold, mem_freeze}
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  cur = '0;
    int   tests = 0;
    int   fails = 0;

    // Model state: owed bubbles, mul/div busy, counters
    int     lu_rem [2];
    bit     md_busy[2];
    longint sc[2], fc[2];
    int     nb[2];
    longint cmax[2];
    int     obs_bub[2], obs_hold[2], obs_frz[2];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.CNT_W(CW_A)) hz_a ();
    hazard_ctrl_if #(.CNT_W(CW_B)) hz_b ();

    hazard_ctrl #(.LU_BUBBLES(3), .CNT_W(CW_A)) dut_a (.clk(clk), .rst_n(rst_n), .hz(hz_a));
    hazard_ctrl #(.LU_BUBBLES(1), .CNT_W(CW_B)) dut_b (.clk(clk), .rst_n(rst_n), .hz(hz_b));

    assign hz_a.id_valid = cur.id_valid;     assign hz_b.id_valid = cur.id_valid;
    assign hz_a.id_rs1 = cur.id_rs1;         assign hz_b.id_rs1 = cur.id_rs1;
    assign hz_a.id_rs2 = cur.id_rs2;         assign hz_b.id_rs2 = cur.id_rs2;
    assign hz_a.id_uses_rs2 = cur.id_uses_rs2; assign hz_b.id_uses_rs2 = cur.id_uses_rs2;
    assign hz_a.ex_rd = cur.ex_rd;           assign hz_b.ex_rd = cur.ex_rd;
    assign hz_a.ex_mem_read = cur.ex_mem_read; assign hz_b.ex_mem_read = cur.ex_mem_read;
    assign hz_a.ex_branch_taken = cur.br;    assign hz_b.ex_branch_taken = cur.br;
    assign hz_a.ex_muldiv_start = cur.mds;   assign hz_b.ex_muldiv_start = cur.mds;
    assign hz_a.muldiv_done = cur.done;      assign hz_b.muldiv_done = cur.done;
    assign hz_a.mem_req = cur.mreq;          assign hz_b.mem_req = cur.mreq;
    assign hz_a.mem_ready = cur.mrdy;        assign hz_b.mem_ready = cur.mrdy;

    wire [5:0] ctrl_a = {hz_a.pc_stall, hz_a.if_id_stall, hz_a.if_id_flush,
                         hz_a.id_ex_bubble, hz_a.ex_hold, hz_a.mem_freeze};
    wire [5:0] ctrl_b = {hz_b.pc_stall, hz_b.if_id_stall, hz_b.if_id_flush,
                         hz_b.id_ex_bubble, hz_b.ex_hold, hz_b.mem_freeze};

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint exp_cnt(input longint v);
`ifdef HAZARD_PERF_CNT_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    function automatic in_t mk(input logic v, input int rs1, input int rs2, input logic u2,
                               input int rd, input logic mr, input logic br, input logic mds,
                               input logic done, input logic mreq, input logic mrdy);
        in_t r;
        r.id_valid = v;  r.id_rs1 = 5'(rs1); r.id_rs2 = 5'(rs2); r.id_uses_rs2 = u2;
        r.ex_rd = 5'(rd); r.ex_mem_read = mr; r.br = br; r.mds = mds; r.done = done;
        r.mreq = mreq; r.mrdy = mrdy;
        return r;
    endfunction

    function automatic void clear_model();
        for (int k = 0; k < 2; k++) begin
            lu_rem[k] = 0; md_busy[k] = 0; sc[k] = 0; fc[k] = 0;
        end
    endfunction

    // Behavioural reference: priorities over "bubbles still owed" and "mul/div busy"
    function automatic void model(input int k, input bit commit, output logic [5:0] ctrl, output int st);
        bit mwait;
        bit lu;
        mwait = cur.mreq && !cur.mrdy;
        lu = cur.id_valid && cur.ex_mem_read && cur.ex_rd != 0 &&
             (cur.ex_rd == cur.id_rs1 || (cur.id_uses_rs2 && cur.ex_rd == cur.id_rs2));
        st = md_busy[k] ? 2 : (lu_rem[k] > 0 ? 1 : 0);
        ctrl = 6'b000000;
        if (mwait) ctrl = 6'b110011;
        else if (lu_rem[k] > 0) begin
            ctrl = 6'b110100;
            if (commit) lu_rem[k]--;
        end else if (md_busy[k]) begin
            if (cur.done) begin
                if (commit) md_busy[k] = 0;
            end else ctrl = 6'b110010;
        end else if (cur.br) ctrl = 6'b001100;
        else if (cur.mds) begin
            ctrl = 6'b110010;
            if (commit) md_busy[k] = 1;
        end else if (lu) begin
            ctrl = 6'b110100;
            if (commit) lu_rem[k] = nb[k] - 1;
        end
        if (commit) begin
            if (ctrl[5] && sc[k] < cmax[k]) sc[k]++;
            if (ctrl[3] && fc[k] < cmax[k]) fc[k]++;
        end
    endfunction

    // One cycle: check at negedge, advance model at posedge, return to posedge+1
    task automatic step(input bit use_tbl, input logic [5:0] texp);
        logic [5:0] ea, eb;
        int sa, sb;
        @(negedge clk);
        model(0, 0, ea, sa);
        model(1, 0, eb, sb);
        chk("ctrl_a", longint'(ctrl_a), longint'(ea));
        chk("state_a", longint'(hz_a.state), longint'(sa));
        chk("stall_cycles_a", longint'(hz_a.stall_cycles), exp_cnt(sc[0]));
        chk("flush_count_a", longint'(hz_a.flush_count), exp_cnt(fc[0]));
        chk("ctrl_b", longint'(ctrl_b), longint'(eb));
        chk("state_b", longint'(hz_b.state), longint'(sb));
        chk("stall_cycles_b", longint'(hz_b.stall_cycles), exp_cnt(sc[1]));
        chk("flush_count_b", longint'(hz_b.flush_count), exp_cnt(fc[1]));
        if (use_tbl) begin
            chk("tbl_ctrl_a", longint'(ctrl_a), longint'(texp));
            chk("tbl_ctrl_b", longint'(ctrl_b), longint'(texp));
        end
        obs_bub[0] += int'(hz_a.id_ex_bubble); obs_bub[1] += int'(hz_b.id_ex_bubble);
        obs_hold[0] += int'(hz_a.ex_hold);     obs_hold[1] += int'(hz_b.ex_hold);
        obs_frz[0] += int'(hz_a.mem_freeze);   obs_frz[1] += int'(hz_b.mem_freeze);
        @(posedge clk);
        model(0, 1, ea, sa);
        model(1, 1, eb, sb);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        cur = '0;
        clear_model();
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_obs();
        for (int k = 0; k < 2; k++) begin
            obs_bub[k] = 0; obs_hold[k] = 0; obs_frz[k] = 0;
        end
    endtask

    vec_t tbl[13];

    initial begin
        nb[0] = 3; nb[1] = 1;
        cmax[0] = (longint'(1) << CW_A) - 1;
        cmax[1] = (longint'(1) << CW_B) - 1;
        clear_model();
        clr_obs();

        //                v  rs1 rs2 u2 rd mr br mds dn mq mr
        tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 6'b000000};
        tbl[1]  = '{mk(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0), 6'b110100};
        tbl[2]  = '{mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), 6'b000000};
        tbl[3]  = '{mk(1, 3, 7, 1, 7, 1, 0, 0, 0, 0, 0), 6'b110100};
        tbl[4]  = '{mk(1, 3, 7, 0, 7, 1, 0, 0, 0, 0, 0), 6'b000000};
        tbl[5]  = '{mk(0, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0), 6'b000000};
        tbl[6]  = '{mk(1, 5, 0, 0, 5, 0, 0, 0, 0, 0, 0), 6'b000000};
        tbl[7]  = '{mk(1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0), 6'b001100};
        tbl[8]  = '{mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), 6'b001100};
        tbl[9]  = '{mk(1, 5, 0, 0, 5, 1, 0, 1, 0, 0, 0), 6'b110010};
        tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0), 6'b110011};
        tbl[11] = '{mk(1, 5, 0, 0, 5, 1, 1, 0, 0, 1, 1), 6'b001100};
        tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0), 6'b000000};

        // Reset state while held in reset
        #3;
        chk("reset_ctrl_a", longint'(ctrl_a), 0);
        chk("reset_state_a", longint'(hz_a.state), 0);
        chk("reset_ctrl_b", longint'(ctrl_b), 0);
        do_reset();

        // Single-cycle vectors from RUN
        for (int i = 0; i < 13; i++) begin
            do_reset();
            cur = tbl[i].in;
            step(1'b1, tbl[i].exp);
        end

        // Load-use: A gives 3 bubbles (state 0,1,1,0), B gives 1
        do_reset(); clr_obs();
        cur = mk(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        step(1'b0, '0);
        chk("lu3_state_1", longint'(hz_a.state), 1);
        cur = '0;
        step(1'b0, '0);
        chk("lu3_state_2", longint'(hz_a.state), 1);
        step(1'b0, '0);
        chk("lu3_state_3", longint'(hz_a.state), 0);
        step(1'b0, '0);
        chk("lu_bubbles_a", obs_bub[0], 3);
        chk("lu_bubbles_b", obs_bub[1], 1);
        chk("lu_stalls_a", longint'(hz_a.stall_cycles), exp_cnt(3));

        // Branch beats load-use
        do_reset();
        cur = mk(1, 5, 0, 0, 5, 1, 1, 0, 0, 0, 0);
        step(1'b0, '0);
        cur = '0;
        chk("br_flush_count_a", longint'(hz_a.flush_count), exp_cnt(1));
        step(1'b0, '0);

        // Mul/div: start pulse, done four cycles later
        do_reset(); clr_obs();
        cur.mds = 1'b1;
        step(1'b0, '0);
        cur = '0;
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        cur.done = 1'b1;
        step(1'b0, '0);
        cur = '0;
        step(1'b0, '0);
        chk("md_hold_a", obs_hold[0], 4);
        chk("md_hold_b", obs_hold[1], 4);
        chk("md_state_a", longint'(hz_a.state), 0);

        // Memory freeze stretches LOAD_USE
        do_reset(); clr_obs();
        cur = mk(1, 5, 0, 0, 5, 1, 0, 0, 0, 0, 0);
        step(1'b0, '0);
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        chk("frz_state_held_a", longint'(hz_a.state), 1);
        cur = '0;
        for (int i = 0; i < 3; i++) step(1'b0, '0);
        chk("frz_cycles_a", obs_frz[0], 3);
        chk("frz_bubbles_a", obs_bub[0], 3);

        // Asynchronous reset mid-MULDIV
        do_reset();
        cur.mds = 1'b1;
        step(1'b0, '0);
        cur = '0;
        step(1'b0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ctrl_a", longint'(ctrl_a), 0);
        chk("arst_state_a", longint'(hz_a.state), 0);
        chk("arst_ctrl_b", longint'(ctrl_b), 0);
        chk("arst_stall_a", longint'(hz_a.stall_cycles), 0);
        clear_model();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Counter saturation on the 4-bit instance
        do_reset();
        cur.mds = 1'b1;
        step(1'b0, '0);
        cur = '0;
        for (int i = 0; i < 20; i++) step(1'b0, '0);
        chk("sat_stall_b", longint'(hz_b.stall_cycles), exp_cnt(15));
        chk("sat_stall_a", longint'(hz_a.stall_cycles), exp_cnt(21));
        cur.done = 1'b1;
        step(1'b0, '0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            cur.id_valid    = ($urandom_range(0, 3) != 0);
            cur.id_rs1      = 5'($urandom_range(0, 3));
            cur.id_rs2      = 5'($urandom_range(0, 3));
            cur.id_uses_rs2 = 1'($urandom_range(0, 1));
            cur.ex_rd       = 5'($urandom_range(0, 3));
            cur.ex_mem_read = 1'($urandom_range(0, 1));
            cur.br          = ($urandom_range(0, 7) == 0);
            cur.mds         = ($urandom_range(0, 7) == 0);
            cur.done        = ($urandom_range(0, 3) == 0);
            cur.mreq        = ($urandom_range(0, 3) == 0);
            cur.mrdy        = 1'($urandom_range(0, 1));
            step(1'b0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
